// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the FSM state encoding, port identifiers and default widths.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Port identifiers as carried in the latched grant id
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Sequencer states; the enum documents the encoding, the FSM uses the constants
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A word access starting on an odd byte address
    function automatic logic is_misaligned(input logic byte_acc, input logic addr_lsb);
        return ~byte_acc & addr_lsb;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the port that did not win last time
// is chosen; a single requester always wins. The pointer moves on update.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       valid
);

    logic last_grant_reg;

    // Pick a winner from the current requests and the last grant
    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last_grant_reg;
        end else begin
            grant = req[1];
        end
    end

    // Remember who won; reset favours port 0 on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= PORT_DBG;
        end else if (update && valid) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 512x8 data memory.
// Port 0 is the CPU load/store stage, port 1 the debug/DMA loader.
// Each access: IDLE (arbitrate, latch) -> ISSUE (drive memory) -> DONE (ack).
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN rejects odd word accesses
// with an error ack and no memory strobes.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_byte,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_byte,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_byte,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;

    logic              id_reg;
    logic              we_reg;
    logic              byte_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;

    logic [1:0]        req_vec;
    logic              grant;
    logic              grant_valid;
    logic              arb_update;

    logic              sel_we;
    logic              sel_byte;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    logic              issue;
    logic              done_ok;
    logic [1:0]        ack_vec;
    logic [DATA_W-1:0] rdata_vec      [2];
    logic [DATA_W-1:0] rdata_hold_reg [2];

    assign req_vec    = {p1_req, p0_req};
    assign arb_update = (state_reg == ST_IDLE) && grant_valid;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vec),
        .update (arb_update),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Route the winning port's request fields toward the latch
    always_comb begin
        sel_we    = grant ? p1_we    : p0_we;
        sel_byte  = grant ? p1_byte  : p0_byte;
        sel_addr  = grant ? p1_addr  : p0_addr;
        sel_wdata = grant ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        sel_err   = is_misaligned(sel_byte, sel_addr[0]);
`else
        sel_err   = 1'b0;
`endif
    end

    // Sequencer next state; a rejected access skips the memory cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = sel_err ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register and request latch, captured only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            id_reg    <= PORT_CPU;
            we_reg    <= 1'b0;
            byte_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (arb_update) begin
                id_reg    <= grant;
                we_reg    <= sel_we;
                byte_reg  <= sel_byte;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                err_reg   <= sel_err;
            end
        end
    end

    // Memory strobes are live only in ISSUE, even if reset lands on that cycle
    assign issue      = (state_reg == ST_ISSUE);
    assign mem_enable = issue;
    assign mem_write  = issue & we_reg;
    assign mem_read   = issue & ~we_reg;
    assign mem_byte   = issue & byte_reg;
    assign mem_addr   = issue ? addr_reg  : '0;
    assign mem_wdata  = issue ? wdata_reg : '0;

    // An in-flight request hit by reset never sees its ack
    assign done_ok = (state_reg == ST_DONE) && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic load;
            assign ack_vec[gi]   = done_ok && (id_reg == 1'(gi));
            assign load          = ack_vec[gi] && !we_reg && !err_reg;
            // Read data goes straight through with the ack, then is held
            assign rdata_vec[gi] = load ? mem_rdata : rdata_hold_reg[gi];

            // Keep the last returned word visible between acks
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_hold_reg[gi] <= '0;
                end else if (load) begin
                    rdata_hold_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign p0_ack   = ack_vec[0];
    assign p1_ack   = ack_vec[1];
    assign p0_rdata = rdata_vec[0];
    assign p1_rdata = rdata_vec[1];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign p0_err = ack_vec[0] & err_reg;
    assign p1_err = ack_vec[1] & err_reg;
`else
    assign p0_err = 1'b0;
    assign p1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, hand-written corner
// sequences and a randomized two-port run against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic        port;
        logic        we;
        logic        byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p0_byte = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0, p1_byte = 1'b0;
    logic [15:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_enable, mem_write, mem_read, mem_byte;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [7:0]  dev_mem [512] = '{default: 8'h00};
    logic [7:0]  ref_mem [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_byte(mem_byte),
        .mem_rdata(mem_rdata)
    );

    // 512x8 memory device: registered read, zero when not reading, wrapping index
    always @(posedge clk) begin
        if (mem_enable && mem_write) begin
            dev_mem[mem_addr[8:0]] <= mem_wdata[7:0];
            if (!mem_byte) dev_mem[9'(mem_addr[8:0] + 9'd1)] <= mem_wdata[15:8];
        end
        if (mem_enable && mem_read)
            mem_rdata <= mem_byte ? {8'h00, dev_mem[mem_addr[8:0]]}
                                  : {dev_mem[9'(mem_addr[8:0] + 9'd1)], dev_mem[mem_addr[8:0]]};
        else
            mem_rdata <= '0;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a, input logic byt);
        int i0, i1;
        i0 = int'(a) % 512;
        i1 = (i0 + 1) % 512;
        return byt ? {8'h00, ref_mem[i0]} : {ref_mem[i1], ref_mem[i0]};
    endfunction

    function automatic void ref_write(input logic [15:0] a, input logic byt, input logic [15:0] wd);
        int i0;
        i0 = int'(a) % 512;
        ref_mem[i0] = wd[7:0];
        if (!byt) ref_mem[(i0 + 1) % 512] = wd[15:8];
    endfunction

    task automatic drive(input int p, input logic r, input logic we, input logic byt,
                         input logic [15:0] a, input logic [15:0] wd);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_byte = byt; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = r; p1_we = we; p1_byte = byt; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Everything the arbiter drives should be quiet (called at a negedge)
    task automatic check_quiet(input string name);
        check({name, " ctl"}, {56'h0, p0_ack, p1_ack, p0_err, p1_err,
                               mem_enable, mem_write, mem_read, mem_byte}, 64'h0);
        check({name, " rdata"}, {32'h0, p0_rdata, p1_rdata}, 64'h0);
        check({name, " mem bus"}, {32'h0, mem_addr, mem_wdata}, 64'h0);
    endtask

    // One isolated transaction; entered and left just after a rising edge in IDLE
    task automatic do_txn(input vec_t v, input int idx);
        logic mis;
        int   lat;
        logic [63:0] exp_mem;
        mis = ALIGN && !v.byt && v.addr[0];
        lat = mis ? 1 : 2;
        drive(int'(v.port), 1'b1, v.we, v.byt, v.addr, v.wdata);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1 && !mis) begin
                exp_mem = {28'h0, 1'b1, v.we, ~v.we, v.byt, v.addr, v.wdata};
                if (v.we) ref_write(v.addr, v.byt, v.wdata);
            end else begin
                exp_mem = 64'h0;
            end
            check($sformatf("vec%0d mem c%0d", idx, c),
                  {28'h0, mem_enable, mem_write, mem_read, mem_byte, mem_addr, mem_wdata}, exp_mem);
            check($sformatf("vec%0d ack c%0d", idx, c), {62'h0, p1_ack, p0_ack},
                  (c == lat) ? (v.port ? 64'h2 : 64'h1) : 64'h0);
            if (c == lat) begin
                check($sformatf("vec%0d rdata", idx), {48'h0, v.port ? p1_rdata : p0_rdata},
                      {48'h0, v.exp_rdata});
                check($sformatf("vec%0d err", idx), {63'h0, v.port ? p1_err : p0_err},
                      {63'h0, v.exp_err});
                $display("txn vec%0d port%0d we=%0b byte=%0b addr=%h wdata=%h rdata=%h err=%0b",
                         idx, v.port, v.we, v.byt, v.addr, v.wdata,
                         v.port ? p1_rdata : p0_rdata, v.port ? p1_err : p0_err);
            end
            @(posedge clk);
            #1;
            if (c == lat) drive(int'(v.port), 1'b0, v.we, v.byt, v.addr, v.wdata);
        end
    endtask

    vec_t vecs [13];

    // Random-run state
    logic        act [2];
    int          gap [2];
    int          left [2];
    logic        r_we [2];
    logic        r_byt [2];
    logic [15:0] r_addr [2];
    logic [15:0] r_wd [2];
    logic [15:0] exp_rd [2];

    initial begin : main
        int          free_at, issue_at, ack_at, cyc, n_ack;
        logic        last, g_port, g_we, g_byt, g_mis;
        logic [15:0] g_addr, g_wd, g_rd;
        logic [7:0]  en_bits, ack_bits;
        logic [11:0] a0_bits, a1_bits;
        int          both;
        vec_t        vc;

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h00BE, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h125A, 16'h00BE, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h005A, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h01FE, 16'h1234, 16'h00BE, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h01FF, 16'h0000, 16'h0012, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0022, 16'h7788, 16'h00BE, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, ALIGN ? 16'h0012 : 16'h8800, ALIGN};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000, 16'h7788, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0220, 16'h0000, 16'h005A, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0011, 16'hFF99, 16'h7788, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h99EF, 1'b0};

        // Reset state
        do_reset();
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) do_txn(vecs[i], i);

        // Port 0 holds req across its ack: back-to-back identical accesses
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        en_bits = '0;
        ack_bits = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            en_bits[c]  = mem_enable;
            ack_bits[c] = p0_ack;
            if (p0_ack) check($sformatf("hold rdata c%0d", c), {48'h0, p0_rdata}, 64'h99EF);
            check($sformatf("hold p1_ack c%0d", c), {63'h0, p1_ack}, 64'h0);
            @(posedge clk);
            #1;
        end
        check("hold enable pattern", {56'h0, en_bits}, 64'h92);
        check("hold ack pattern", {56'h0, ack_bits}, 64'h24);
        $display("txn hold port0 read addr=0010 repeated, enables=%b acks=%b", en_bits, ack_bits);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(posedge clk);
        #1;

        // Both ports requesting continuously from reset
        do_reset();
        @(negedge clk);
        check_quiet("reset2");
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000);
        a0_bits = '0;
        a1_bits = '0;
        both = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a0_bits[c] = p0_ack;
            a1_bits[c] = p1_ack;
            if (p0_ack && p1_ack) both++;
            if (p0_ack || p1_ack)
                $display("txn both-req cycle %0d ack port%0d rdata=%h", c, p1_ack ? 1 : 0,
                         p1_ack ? p1_rdata : p0_rdata);
            @(posedge clk);
            #1;
        end
        check("rr port0 ack cycles", {52'h0, a0_bits}, 64'h104);
        check("rr port1 ack cycles", {52'h0, a1_bits}, 64'h820);
        check("rr simultaneous acks", 64'(both), 64'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #1;

        // Reset during DONE of a port 0 read
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check("rst-in-done ack", {62'h0, p1_ack, p0_ack}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("after rst-in-done");
        @(posedge clk);
        #1;
        vc = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h99EF, 1'b0};
        do_txn(vc, 100);

        // Randomized two-port traffic against the transaction-level model
        do_reset();
        free_at = 0; issue_at = -1; ack_at = -1; last = 1'b1;
        g_port = 1'b0; g_we = 1'b0; g_byt = 1'b0; g_mis = 1'b0;
        g_addr = '0; g_wd = '0; g_rd = '0;
        n_ack = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; gap[p] = 0; left[p] = 60; exp_rd[p] = '0;
            r_we[p] = 1'b0; r_byt[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
        end
        cyc = 0;
        while ((left[0] > 0 || left[1] > 0 || act[0] || act[1] || cyc <= ack_at) && cyc < 4000) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p]) begin
                    if (gap[p] > 0) begin
                        gap[p]--;
                    end else if (left[p] > 0) begin
                        r_we[p]   = 1'($urandom_range(0, 1));
                        r_byt[p]  = 1'($urandom_range(0, 1));
                        r_addr[p] = 16'($urandom_range(0, 63));
                        if ($urandom_range(0, 3) == 0)
                            r_addr[p] = r_addr[p] | 16'h01C0 | (16'($urandom) & 16'hFE00);
                        r_wd[p]   = 16'($urandom);
                        act[p]    = 1'b1;
                        left[p]--;
                    end
                end
                drive(p, act[p], r_we[p], r_byt[p], r_addr[p], r_wd[p]);
            end
            @(negedge clk);
            if (cyc == issue_at) begin
                check($sformatf("rand mem cyc%0d", cyc),
                      {28'h0, mem_enable, mem_write, mem_read, mem_byte, mem_addr, mem_wdata},
                      {28'h0, 1'b1, g_we, ~g_we, g_byt, g_addr, g_wd});
                if (g_we) ref_write(g_addr, g_byt, g_wd);
                else g_rd = ref_read(g_addr, g_byt);
            end else begin
                check($sformatf("rand idle mem cyc%0d", cyc),
                      {28'h0, mem_enable, mem_write, mem_read, mem_byte, mem_addr, mem_wdata}, 64'h0);
            end
            check($sformatf("rand ack cyc%0d", cyc), {62'h0, p1_ack, p0_ack},
                  (cyc == ack_at) ? (g_port ? 64'h2 : 64'h1) : 64'h0);
            if (cyc == ack_at) begin
                if (!g_we && !g_mis) exp_rd[g_port] = g_rd;
                check($sformatf("rand err cyc%0d", cyc), {62'h0, p1_err, p0_err},
                      g_mis ? (g_port ? 64'h2 : 64'h1) : 64'h0);
                $display("txn rand%0d port%0d we=%0b byte=%0b addr=%h wdata=%h rdata=%h err=%0b",
                         n_ack, g_port, g_we, g_byt, g_addr, g_wd,
                         g_port ? p1_rdata : p0_rdata, g_port ? p1_err : p0_err);
                n_ack++;
                act[g_port] = 1'b0;
                gap[g_port] = $urandom_range(0, 2);
            end
            check($sformatf("rand rdata cyc%0d", cyc), {32'h0, p0_rdata, p1_rdata},
                  {32'h0, exp_rd[0], exp_rd[1]});
            if (cyc >= free_at && (act[0] || act[1])) begin
                g_port   = (act[0] && act[1]) ? ~last : act[1];
                last     = g_port;
                g_we     = r_we[g_port];
                g_byt    = r_byt[g_port];
                g_addr   = r_addr[g_port];
                g_wd     = r_wd[g_port];
                g_mis    = ALIGN && !g_byt && g_addr[0];
                issue_at = g_mis ? -1 : cyc + 1;
                ack_at   = cyc + (g_mis ? 1 : 2);
                free_at  = ack_at + 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand completed transactions", 64'(n_ack), 64'd120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
